// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer slice.
// Contents:
//   ROB_DEPTH / ROB_IDX_W   default depth and the index width derived from it
//   PHYS_REG_W              physical register tag width
//   WB_CDB_NUM / CDB_t      number and format of write-back broadcasts
//   rob_entry_t             one ROB slot
//   is_mispredict()         sequential-flow test for a retiring entry
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int PHYS_REG_W = 6;
  localparam int WB_CDB_NUM = 3;

  typedef struct packed {
    logic                 we;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 br_en;
    logic [31:0]          pc_next;
    logic [31:0]          funct_out;
  } CDB_t;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [4:0]            rd;
    logic [PHYS_REG_W-1:0] pd;
    logic [31:0]           pc;
    logic [31:0]           pc_next;
    logic [31:0]           data;
    logic                  br_en;
  } rob_entry_t;

  // Anything other than fall-through to the next word is a redirect.
  function automatic logic is_mispredict(input logic [31:0] pc,
                                         input logic [31:0] pc_next);
    return pc_next != (pc + 32'd4);
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer used for the ROB head and tail.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   inc           advance by one (wraps modulo 2*depth)
//   clr           return to zero, wins over inc
//   other         the opposite pointer, for occupancy compare
//   ptr           pointer value, MSB is the wrap bit
//   empty / full  pointers equal / same index with opposite wrap bits
module rob_ptr #(
  parameter int IDX_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  input  logic           clr,
  input  logic [IDX_W:0] other,
  output logic [IDX_W:0] ptr,
  output logic           empty,
  output logic           full
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + (IDX_W+1)'(1);
    end
  end

  assign empty = (ptr == other);
  assign full  = (ptr[IDX_W-1:0] == other[IDX_W-1:0]) && (ptr[IDX_W] != other[IDX_W]);

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates entries at the tail, marks them
// complete from CDB broadcasts, retires at most one ready head entry per
// cycle and requests a flush when the retiring entry did not fall through.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   alloc_valid/rd/pd/pc          dispatch request and its fields
//   alloc_ready, alloc_rob_idx    slot available, index granted (tail)
//   CDB                           write-back broadcasts
//   commit_valid, commit_*        retiring head entry (zero when idle)
//   flush, redirect_pc            mispredict recovery request and target
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH,
  parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_valid,
  input  logic [4:0]                       alloc_rd,
  input  logic [PHYS_REG_W-1:0]            alloc_pd,
  input  logic [31:0]                      alloc_pc,
  output logic                             alloc_ready,
  output logic [IDX_W-1:0]                 alloc_rob_idx,
  input  CDB_t [WB_CDB_NUM-1:0]            CDB,
  output logic                             commit_valid,
  output logic [4:0]                       commit_rd,
  output logic [PHYS_REG_W-1:0]            commit_pd,
  output logic [31:0]                      commit_pc,
  output logic [31:0]                      commit_pc_next,
  output logic [31:0]                      commit_data,
  output logic                             flush,
  output logic [31:0]                      redirect_pc
);

  rob_entry_t entries [ROB_DEPTH];

  logic [IDX_W:0]   head_ptr;
  logic [IDX_W:0]   tail_ptr;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             head_empty, head_full;
  logic             tail_empty, tail_full;
  logic             rob_empty, rob_full;
  logic             alloc_fire;

  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];

  rob_ptr #(.IDX_W(IDX_W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .inc   (commit_valid),
    .clr   (flush),
    .other (tail_ptr),
    .ptr   (head_ptr),
    .empty (head_empty),
    .full  (head_full)
  );

  rob_ptr #(.IDX_W(IDX_W)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .inc   (alloc_fire),
    .clr   (flush),
    .other (head_ptr),
    .ptr   (tail_ptr),
    .empty (tail_empty),
    .full  (tail_full)
  );

  // Both pointer instances compare the same pair, so their results agree.
  assign rob_empty = head_empty & tail_empty;
  assign rob_full  = head_full & tail_full;

  // Same-cycle commit is deliberately ignored; gating with rst keeps
  // dispatch stalled while reset is held.
  assign alloc_ready   = rst & ~rob_full & ~flush;
  assign alloc_fire    = alloc_valid & alloc_ready;
  assign alloc_rob_idx = tail_idx;

  // Retirement only looks at the registered ready bit, so a CDB write to
  // the head commits one cycle later at the earliest.
  always_comb begin
    commit_valid   = 1'b0;
    commit_rd      = '0;
    commit_pd      = '0;
    commit_pc      = '0;
    commit_pc_next = '0;
    commit_data    = '0;
    flush          = 1'b0;
    redirect_pc    = '0;
    if (!rob_empty && entries[head_idx].valid && entries[head_idx].ready) begin
      commit_valid   = 1'b1;
      commit_rd      = entries[head_idx].rd;
      commit_pd      = entries[head_idx].pd;
      commit_pc      = entries[head_idx].pc;
      commit_pc_next = entries[head_idx].pc_next;
      commit_data    = entries[head_idx].data;
      if (is_mispredict(entries[head_idx].pc, entries[head_idx].pc_next)) begin
        flush       = 1'b1;
        redirect_pc = entries[head_idx].pc_next;
      end
    end
  end

  // Entry storage. A flush wipes every slot and drops whatever alloc or
  // CDB traffic arrived alongside it. Otherwise completions land first,
  // then retirement clears the head, then dispatch fills the tail; the
  // tail slot is never valid when written, so a CDB aimed at it is
  // ignored by the valid check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].ready <= 1'b0;
      end
    end else begin
      for (int i = 0; i < WB_CDB_NUM; i++) begin
        if (CDB[i].we && entries[IDX_W'(CDB[i].rob_idx)].valid) begin
          entries[IDX_W'(CDB[i].rob_idx)].ready   <= 1'b1;
          entries[IDX_W'(CDB[i].rob_idx)].br_en   <= CDB[i].br_en;
          entries[IDX_W'(CDB[i].rob_idx)].pc_next <= CDB[i].pc_next;
          entries[IDX_W'(CDB[i].rob_idx)].data    <= CDB[i].funct_out;
        end
      end
      if (commit_valid) begin
        entries[head_idx].valid <= 1'b0;
        entries[head_idx].ready <= 1'b0;
      end
      if (alloc_fire) begin
        entries[tail_idx].valid   <= 1'b1;
        entries[tail_idx].ready   <= 1'b0;
        entries[tail_idx].rd      <= alloc_rd;
        entries[tail_idx].pd      <= alloc_pd;
        entries[tail_idx].pc      <= alloc_pc;
        entries[tail_idx].pc_next <= '0;
        entries[tail_idx].data    <= '0;
        entries[tail_idx].br_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by
// randomized dispatch/completion traffic, all compared against an
// age-ordered queue model of in-flight instructions.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = ROB_DEPTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  alloc_valid = 1'b0;
  logic [4:0]            alloc_rd = '0;
  logic [PHYS_REG_W-1:0] alloc_pd = '0;
  logic [31:0]           alloc_pc = '0;
  logic                  alloc_ready;
  logic [ROB_IDX_W-1:0]  alloc_rob_idx;
  CDB_t [WB_CDB_NUM-1:0] CDB = '0;
  logic                  commit_valid;
  logic [4:0]            commit_rd;
  logic [PHYS_REG_W-1:0] commit_pd;
  logic [31:0]           commit_pc;
  logic [31:0]           commit_pc_next;
  logic [31:0]           commit_data;
  logic                  flush;
  logic [31:0]           redirect_pc;

  reorder_buffer #(.ROB_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_rd       (alloc_rd),
    .alloc_pd       (alloc_pd),
    .alloc_pc       (alloc_pc),
    .alloc_ready    (alloc_ready),
    .alloc_rob_idx  (alloc_rob_idx),
    .CDB            (CDB),
    .commit_valid   (commit_valid),
    .commit_rd      (commit_rd),
    .commit_pd      (commit_pd),
    .commit_pc      (commit_pc),
    .commit_pc_next (commit_pc_next),
    .commit_data    (commit_data),
    .flush          (flush),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // In-flight instructions, oldest first.
  typedef struct {
    int                    idx;
    logic [4:0]            rd;
    logic [PHYS_REG_W-1:0] pd;
    logic [31:0]           pc;
    logic [31:0]           pc_next;
    logic [31:0]           data;
    bit                    done;
  } rec_t;

  rec_t model_q[$];
  int   next_idx = 0;
  int   num_checks = 0;
  int   num_fails = 0;

  // Staged inputs, driven onto the DUT at the next falling edge.
  logic                  s_alloc_valid;
  logic [4:0]            s_rd;
  logic [PHYS_REG_W-1:0] s_pd;
  logic [31:0]           s_pc;
  CDB_t                  s_cdb [WB_CDB_NUM];

  // Two broadcasts to the same slot in one cycle are illegal stimulus.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WB_CDB_NUM; i++) begin
        for (int j = i + 1; j < WB_CDB_NUM; j++) begin
          assert (!(CDB[i].we && CDB[j].we && CDB[i].rob_idx == CDB[j].rob_idx))
            else $error("[TB] duplicate CDB rob_idx %0d on slots %0d and %0d", CDB[i].rob_idx, i, j);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stage();
    s_alloc_valid = 1'b0;
    s_rd = '0;
    s_pd = '0;
    s_pc = '0;
    for (int i = 0; i < WB_CDB_NUM; i++) s_cdb[i] = '0;
  endtask

  task automatic stage_alloc(input logic [31:0] pc, input int tag);
    s_alloc_valid = 1'b1;
    s_pc = pc;
    s_rd = 5'(tag);
    s_pd = PHYS_REG_W'(tag + 7);
  endtask

  task automatic stage_cdb(input int slot, input int idx, input logic [31:0] pc_next,
                           input logic [31:0] data);
    s_cdb[slot] = '{we: 1'b1, rob_idx: ROB_IDX_W'(idx), br_en: 1'b0,
                    pc_next: pc_next, funct_out: data};
  endtask

  // One clock cycle: drive staged inputs, check every output against the
  // model's view of the current cycle, then advance the model past the edge.
  task automatic applyStimulus();
    bit   exp_commit, exp_flush, exp_ready;
    rec_t h;
    @(negedge clk);
    alloc_valid = s_alloc_valid;
    alloc_rd    = s_rd;
    alloc_pd    = s_pd;
    alloc_pc    = s_pc;
    for (int i = 0; i < WB_CDB_NUM; i++) CDB[i] = s_cdb[i];
    #1;
    exp_commit = (model_q.size() > 0) && model_q[0].done;
    exp_flush  = exp_commit && (model_q[0].pc_next != model_q[0].pc + 32'd4);
    exp_ready  = (model_q.size() < DEPTH) && !exp_flush;
    h = '{idx: 0, rd: '0, pd: '0, pc: '0, pc_next: '0, data: '0, done: 1'b0};
    if (exp_commit) h = model_q[0];
    checkOutput("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    checkOutput("alloc_rob_idx", 32'(alloc_rob_idx), 32'(next_idx));
    checkOutput("commit_valid", 32'(commit_valid), 32'(exp_commit));
    checkOutput("flush", 32'(flush), 32'(exp_flush));
    checkOutput("redirect_pc", redirect_pc, exp_flush ? h.pc_next : 32'h0);
    checkOutput("commit_rd", 32'(commit_rd), 32'(h.rd));
    checkOutput("commit_pd", 32'(commit_pd), 32'(h.pd));
    checkOutput("commit_pc", commit_pc, h.pc);
    checkOutput("commit_pc_next", commit_pc_next, h.pc_next);
    checkOutput("commit_data", commit_data, h.data);
    if (exp_flush) begin
      model_q.delete();
      next_idx = 0;
    end else begin
      for (int i = 0; i < WB_CDB_NUM; i++) begin
        if (s_cdb[i].we) begin
          foreach (model_q[k]) begin
            if (model_q[k].idx == int'(s_cdb[i].rob_idx)) begin
              model_q[k].done    = 1'b1;
              model_q[k].pc_next = s_cdb[i].pc_next;
              model_q[k].data    = s_cdb[i].funct_out;
            end
          end
        end
      end
      if (exp_commit) void'(model_q.pop_front());
      if (s_alloc_valid && exp_ready) begin
        model_q.push_back('{idx: next_idx, rd: s_rd, pd: s_pd, pc: s_pc,
                            pc_next: '0, data: '0, done: 1'b0});
        next_idx = (next_idx + 1) % DEPTH;
      end
    end
  endtask

  // Pull reset at a falling edge, check outputs go quiet at once, hold,
  // then release at a later falling edge.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    alloc_valid = 1'b0;
    CDB = '0;
    clear_stage();
    #1;
    checkOutput("rst_alloc_ready", 32'(alloc_ready), 32'h0);
    checkOutput("rst_commit_valid", 32'(commit_valid), 32'h0);
    checkOutput("rst_flush", 32'(flush), 32'h0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("rst_commit_pc", commit_pc, 32'h0);
    model_q.delete();
    next_idx = 0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      clear_stage();
      stage_alloc(base + 32'(4 * k), k);
      applyStimulus();
      checkOutput("fill_idx", 32'(alloc_rob_idx), 32'(k));
    end
    clear_stage();
  endtask

  initial begin
    int   cand[$];
    bit   used [DEPTH];
    int   j, k, t;
    bit   busy;
    logic [31:0] pcv, pnext;

    clear_stage();
    do_reset(3);

    // Sixteen dispatches with nothing completing: fills, never retires.
    fill(16, 32'h100);
    applyStimulus();
    checkOutput("full_alloc_ready", 32'(alloc_ready), 32'h0);
    checkOutput("full_no_commit", 32'(commit_valid), 32'h0);

    // Out-of-order completion, in-order retirement.
    do_reset(2);
    fill(3, 32'h400);
    stage_cdb(2, 1, 32'h408, 32'hAAAA_0001);
    applyStimulus();
    clear_stage();
    stage_cdb(0, 0, 32'h404, 32'hAAAA_0000);
    applyStimulus();
    checkOutput("head_write_no_same_cycle_commit", 32'(commit_valid), 32'h0);
    clear_stage();
    applyStimulus();
    checkOutput("ooo_commit0_pc", commit_pc, 32'h400);
    applyStimulus();
    checkOutput("ooo_commit1_pc", commit_pc, 32'h404);
    applyStimulus();
    checkOutput("ooo_idx2_held", 32'(commit_valid), 32'h0);

    // Mispredict: flush with commit, alloc/CDB in the flush cycle dropped.
    do_reset(2);
    clear_stage();
    stage_alloc(32'h200, 1);
    applyStimulus();
    clear_stage();
    stage_alloc(32'h500, 2);
    applyStimulus();
    clear_stage();
    stage_cdb(0, 0, 32'h300, 32'h1234);
    applyStimulus();
    clear_stage();
    stage_alloc(32'h600, 3);
    stage_cdb(1, 1, 32'h504, 32'h5555);
    applyStimulus();
    checkOutput("mp_flush", 32'(flush), 32'h1);
    checkOutput("mp_redirect", redirect_pc, 32'h300);
    clear_stage();
    applyStimulus();
    checkOutput("mp_after_idx", 32'(alloc_rob_idx), 32'h0);
    checkOutput("mp_after_empty", 32'(commit_valid), 32'h0);

    // Full ROB with head retiring: stall that cycle, grant after wrap.
    do_reset(2);
    fill(16, 32'h1000);
    stage_alloc(32'h2000, 9);
    stage_cdb(0, 0, 32'h1004, 32'h77);
    applyStimulus();
    for (int i = 0; i < WB_CDB_NUM; i++) s_cdb[i] = '0;
    applyStimulus();
    checkOutput("wrap_commit_cycle_ready", 32'(alloc_ready), 32'h0);
    checkOutput("wrap_commit_cycle_valid", 32'(commit_valid), 32'h1);
    applyStimulus();
    checkOutput("wrap_grant_ready", 32'(alloc_ready), 32'h1);
    checkOutput("wrap_grant_idx", 32'(alloc_rob_idx), 32'h0);
    clear_stage();

    // Reset in the middle of retiring traffic.
    do_reset(2);
    fill(5, 32'h3000);
    stage_cdb(0, 0, 32'h3004, 32'h10);
    stage_cdb(1, 1, 32'h3008, 32'h11);
    stage_cdb(2, 2, 32'h300C, 32'h12);
    applyStimulus();
    clear_stage();
    stage_cdb(0, 3, 32'h3010, 32'h13);
    stage_cdb(1, 4, 32'h3014, 32'h14);
    applyStimulus();
    do_reset(2);
    applyStimulus();
    checkOutput("post_rst_idx", 32'(alloc_rob_idx), 32'h0);
    checkOutput("post_rst_no_commit", 32'(commit_valid), 32'h0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end
      clear_stage();
      for (int i = 0; i < DEPTH; i++) used[i] = 1'b0;
      if ($urandom_range(0, 99) < 60) begin
        stage_alloc($urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 31)));
      end
      cand.delete();
      foreach (model_q[q]) if (!model_q[q].done) cand.push_back(q);
      for (int s = 0; s < WB_CDB_NUM; s++) begin
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
          j = int'($urandom_range(0, cand.size() - 1));
          k = cand[j];
          cand.delete(j);
          pcv = model_q[k].pc;
          pnext = ($urandom_range(0, 99) < 6) ? ($urandom & 32'hFFFF_FFFC) : pcv + 32'd4;
          stage_cdb(s, model_q[k].idx, pnext, $urandom);
          used[model_q[k].idx] = 1'b1;
        end else if ($urandom_range(0, 9) == 0) begin
          t = int'($urandom_range(0, DEPTH - 1));
          busy = used[t];
          foreach (model_q[q]) if (model_q[q].idx == t) busy = 1'b1;
          if (!busy) begin
            stage_cdb(s, t, $urandom, $urandom);
            used[t] = 1'b1;
          end
        end
      end
      applyStimulus();
    end

    clear_stage();
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of entries; power of two, at least 4.
REQ-002 Parameter IDX_W, default $clog2(ROB_DEPTH), width of the ROB index.
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 alloc_valid  in  1  dispatch requests one entry.
REQ-007 alloc_rd / alloc_pd / alloc_pc  in  5 / PHYS_REG_W / 32  architectural dest, physical dest, instruction PC.
REQ-008 alloc_ready  out  1  entry available.
REQ-009 alloc_rob_idx  out  IDX_W  index granted (tail).
REQ-010 CDB  in  CDB_t[WB_CDB_NUM]  broadcasts from write-back; we, rob_idx, br_en, pc_next, funct_out used.
REQ-011 commit_valid  out  1  head entry retires this cycle.
REQ-012 commit_rd / commit_pd / commit_pc / commit_pc_next / commit_data  out  5 / PHYS_REG_W / 32 / 32 / 32  retiring entry fields.
REQ-013 flush / redirect_pc  out  1 / 32  mispredict recovery request and target.

Function
REQ-014 Head and tail SHALL be IDX_W+1 bits; empty = pointers equal; full = index bits equal, wrap bits differ.
REQ-015 alloc_ready SHALL equal (not full) and (not flush); it SHALL NOT account for a same-cycle commit.
REQ-016 On alloc_valid and alloc_ready, entry[tail] SHALL be written valid=1, ready=0, and tail incremented modulo 2*ROB_DEPTH; alloc_rob_idx = tail index bits.
REQ-017 For each CDB i with we=1 whose rob_idx addresses a valid entry, that entry SHALL latch ready=1, br_en, pc_next and funct_out at the next edge; CDBs to invalid entries SHALL be ignored.
REQ-018 Two CDBs with we=1 and equal rob_idx in one cycle is illegal; the bench SHALL assert on it.
REQ-019 commit_valid SHALL be combinational: head entry valid and registered ready=1; a CDB write to head commits no earlier than the following cycle.
REQ-020 On commit, head entry SHALL be invalidated and head incremented at the edge; at most one commit per cycle.
REQ-021 Mispredict: committing entry with pc_next != pc+4 SHALL assert flush=1 and redirect_pc=pc_next in the same cycle as commit_valid.
REQ-022 At the edge after flush, all valid bits SHALL clear and head=tail=0; alloc and CDB writes in the flush cycle SHALL be dropped.
REQ-023 Alloc and commit in the same non-full cycle SHALL both take effect; occupancy unchanged.
REQ-024 Full ROB with commit: alloc_ready stays 0 that cycle; alloc accepted the next cycle.

Reset
REQ-025 While rst=0: head=tail=0, all valid/ready bits 0; alloc_ready=0 during reset, 1 in the first cycle after release; commit_valid=0, flush=0, redirect_pc=0, all commit_* data outputs 0 when commit_valid=0.
REQ-026 Reset asserted mid-operation SHALL discard all entries immediately without producing a commit.

Structure
REQ-027 ROB_DEPTH, rob_entry_t (valid, ready, rd, pd, pc, pc_next, data, br_en) and the IDX_W derivation SHALL live in the shared package alongside CDB_t and WB_CDB_NUM.
REQ-028 One sub-module rob_ptr (wrap-bit pointer with increment, clear, full/empty compare) SHALL be instantiated for head and tail.

Verification
REQ-029 Reset release, 16 allocs with pc=0x100+4k, no CDB -> alloc_ready=0 after 16th, rob_idx 0..15, commit_valid never 1.
REQ-030 Fill 3 entries, CDB[2] writes idx 1 then CDB[0] writes idx 0 -> commit idx 0 the cycle after its write, idx 1 the next; idx 2 held.
REQ-031 CDB write to head idx 0 -> commit_valid 1 exactly one cycle later, not same cycle.
REQ-032 Entry pc=0x200 completes with pc_next=0x300 -> flush=1, redirect_pc=0x300 with commit; next cycle all empty, alloc_rob_idx=0.
REQ-033 Full ROB, head ready, alloc_valid held -> commit cycle alloc_ready=0; next cycle alloc granted idx 0 after wrap.
REQ-034 rst pulled low with 5 entries ready -> no commit, alloc_ready=0; after release empty and alloc_rob_idx=0.
